// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory request arbiter.
package mem_arb_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 512;
  localparam int TIMEOUT_CYC_DEF = 4096;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_BUSY = 2'd1,
    ST_WR_BUSY = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_arb_op_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after ptr,
// wrapping modulo NUM_CH. Output is one-hot plus the winner's index.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  int idx;

  // Scan channels starting at ptr; the first hit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (!gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel round-robin arbiter in front of the single-outstanding
// memory request port. One request is in flight at a time; completions are
// routed back to the channel that owns the latched grant.
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable the busy watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_rd_req,
  input  logic [NUM_CH-1:0]              ch_wr_req,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wr_data,
  output logic [NUM_CH-1:0]              ch_ack,
  output logic [NUM_CH-1:0]              ch_rd_vld,
  output logic [DATA_W-1:0]              ch_rd_data,
  output logic [NUM_CH-1:0]              ch_wr_done,
  output logic [NUM_CH-1:0]              ch_err,
  input  logic                           buffer_addr_valid,
  input  logic                           data_valid,
  input  logic                           write_done,
  input  logic [DATA_W-1:0]              read_data,
  output logic                           read_request_valid,
  output logic                           write_request_valid,
  output logic [ADDR_W-1:0]              address,
  output logic [DATA_W-1:0]              write_data,
  output logic                           err_sticky
);

  localparam int PTR_W = $clog2(NUM_CH);

  mem_arb_state_t      state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    ch_q, ch_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic [NUM_CH-1:0]   rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_CH-1:0]   wr_done_q, wr_done_d;

  logic [NUM_CH-1:0]   gnt;
  logic [PTR_W-1:0]    gnt_idx;
  logic                gnt_vld;
  mem_arb_op_t         op_sel;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   err_q, err_d;
  logic                sticky_q, sticky_d;
  logic                tmo;
  logic                tmo_fire;

  // Watchdog expires on the TIMEOUT_CYC-th busy cycle.
  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`endif

  rr_arbiter #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_rr (
    .req     (ch_rd_req | ch_wr_req),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // A channel asserting both reads first; its write stays pending.
  assign op_sel = ch_rd_req[gnt_idx] ? OP_RD : OP_WR;

  // Next-state: grant in IDLE, wait for the matching completion when busy.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ch_d      = ch_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ack_d     = '0;
    rd_vld_d  = '0;
    rd_data_d = rd_data_q;
    wr_done_d = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_fire  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (buffer_addr_valid && gnt_vld) begin
          ch_d     = gnt_idx;
          addr_d   = ch_addr[gnt_idx];
          wdata_d  = ch_wr_data[gnt_idx];
          ack_d    = gnt;
          rr_ptr_d = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
          state_d  = (op_sel == OP_RD) ? ST_RD_BUSY : ST_WR_BUSY;
        end
      end
      ST_RD_BUSY: begin
        if (data_valid) begin
          rd_vld_d[ch_q] = 1'b1;
          rd_data_d      = read_data;
          state_d        = ST_IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo) begin
          tmo_fire = 1'b1;
          state_d  = ST_IDLE;
        end
`endif
      end
      ST_WR_BUSY: begin
        if (write_done) begin
          wr_done_d[ch_q] = 1'b1;
          state_d         = ST_IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo) begin
          tmo_fire = 1'b1;
          state_d  = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers; reset aborts any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      ch_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack_q     <= '0;
      rd_vld_q  <= '0;
      rd_data_q <= '0;
      wr_done_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      wr_done_q <= wr_done_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Busy-cycle counter (zero whenever idle) and error pulse/sticky flag.
  always_comb begin
    cnt_d    = (state_q == ST_IDLE) ? '0 : cnt_q + CNT_W'(1);
    err_d    = '0;
    if (tmo_fire) err_d[ch_q] = 1'b1;
    sticky_d = sticky_q | tmo_fire;
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      err_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign ch_err     = err_q;
  assign err_sticky = sticky_q;
`else
  assign ch_err     = '0;
  assign err_sticky = 1'b0;
`endif

  assign ch_ack              = ack_q;
  assign ch_rd_vld           = rd_vld_q;
  assign ch_rd_data          = rd_data_q;
  assign ch_wr_done          = wr_done_q;
  assign read_request_valid  = (state_q == ST_RD_BUSY);
  assign write_request_valid = (state_q == ST_WR_BUSY);
  assign address             = addr_q;
  assign write_data          = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: each test pushes the pulses it expects
// (ack / read-valid / write-done / error) and a negedge monitor pops and
// compares every pulse the DUT emits.
module tb_mem_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 512;

  localparam int K_ACK = 0;
  localparam int K_RDV = 1;
  localparam int K_WRD = 2;
  localparam int K_ERR = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NCH-1:0]            ch_rd_req, ch_wr_req;
  logic [NCH-1:0][AW-1:0]    ch_addr;
  logic [NCH-1:0][DW-1:0]    ch_wr_data;
  logic [NCH-1:0]            ch_ack, ch_rd_vld, ch_wr_done, ch_err;
  logic [DW-1:0]             ch_rd_data;
  logic                      bav, data_valid, write_done;
  logic [DW-1:0]             read_data;
  logic                      rrv, wrv;
  logic [AW-1:0]             address;
  logic [DW-1:0]             write_data;
  logic                      err_sticky;

  always #5 clk = ~clk;

  mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ch_rd_req           (ch_rd_req),
    .ch_wr_req           (ch_wr_req),
    .ch_addr             (ch_addr),
    .ch_wr_data          (ch_wr_data),
    .ch_ack              (ch_ack),
    .ch_rd_vld           (ch_rd_vld),
    .ch_rd_data          (ch_rd_data),
    .ch_wr_done          (ch_wr_done),
    .ch_err              (ch_err),
    .buffer_addr_valid   (bav),
    .data_valid          (data_valid),
    .write_done          (write_done),
    .read_data           (read_data),
    .read_request_valid  (rrv),
    .write_request_valid (wrv),
    .address             (address),
    .write_data          (write_data),
    .err_sticky          (err_sticky)
  );

  typedef struct {
    int            kind;
    logic [NCH-1:0] mask;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input logic [NCH-1:0] mask, input logic [DW-1:0] data);
    exp_t e;
    e.kind = kind;
    e.mask = mask;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag, input int kind, input logic [NCH-1:0] obs,
                         input logic [DW-1:0] dat);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, DW'(obs), DW'(0));
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_kind"}, DW'(kind), DW'(e.kind));
      chk(tag, DW'(obs), DW'(e.mask));
      if (kind == K_RDV) chk({tag, "_data"}, dat, e.data);
    end
  endtask

  // Every output pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (ch_ack     != '0) pop_cmp("sb_ack",  K_ACK, ch_ack,     '0);
    if (ch_rd_vld  != '0) pop_cmp("sb_rdv",  K_RDV, ch_rd_vld,  ch_rd_data);
    if (ch_wr_done != '0) pop_cmp("sb_wrd",  K_WRD, ch_wr_done, '0);
    if (ch_err     != '0) pop_cmp("sb_err",  K_ERR, ch_err,     '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_wrv(input string tag);
    int n = 0;
    while (!wrv && n < 20) begin
      step();
      n++;
    end
    chk(tag, DW'(wrv), DW'(1));
  endtask

  logic [DW-1:0] wd [NCH];
  logic [DW-1:0] d_ab, d_r, d_c, d_d;
  int            ord [4];
  int            nb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    d_ab = {64{8'hAB}};
    d_r  = {16{32'h1234_5678}};
    d_c  = {16{32'hCAFE_F00D}};
    d_d  = {16{32'hDEAD_BEEF}};
    for (int i = 0; i < NCH; i++) begin
      wd[i]         = {16{32'hC0DE_0000 + 32'(i)}};
      ch_wr_data[i] = wd[i];
      ch_addr[i]    = '0;
    end
    ord = '{0, 1, 3, 0};
    rst = 1'b1; ch_rd_req = '0; ch_wr_req = '0;
    bav = 1'b0; data_valid = 1'b0; write_done = 1'b0; read_data = '0;
    repeat (3) step();

    // Reset state
    chk("rst_rrv",    DW'(rrv),        DW'(0));
    chk("rst_wrv",    DW'(wrv),        DW'(0));
    chk("rst_ack",    DW'(ch_ack),     DW'(0));
    chk("rst_rdata",  ch_rd_data,      DW'(0));
    chk("rst_addr",   DW'(address),    DW'(0));
    chk("rst_sticky", DW'(err_sticky), DW'(0));
    rst = 1'b0; bav = 1'b1;
    step();

    // Test 1: channel 2 read of 0x40
    ch_addr[2] = 32'h40; ch_rd_req[2] = 1'b1;
    push(K_ACK, 4'b0100, '0);
    step();
    chk("t1_rrv",  DW'(rrv),     DW'(1));
    chk("t1_wrv",  DW'(wrv),     DW'(0));
    chk("t1_addr", DW'(address), DW'(32'h40));
    ch_rd_req[2] = 1'b0;
    step(); step();
    chk("t1_hold", DW'(rrv), DW'(1));
    read_data = d_ab; data_valid = 1'b1;
    push(K_RDV, 4'b0100, d_ab);
    step();
    data_valid = 1'b0;
    chk("t1_rrv_low", DW'(rrv),       DW'(0));
    chk("t1_rdvld",   DW'(ch_rd_vld), DW'(4'b0100));
    chk("t1_rdata",   ch_rd_data,     d_ab);
    // A completion while idle is ignored
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    step();
    chk("t1_idle_dv", DW'(ch_rd_vld), DW'(0));

    // Test 2: channels 0,1,3 write continuously from rr_ptr=0
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < NCH; i++) ch_addr[i] = 32'h100 * 32'(i);
    for (int k = 0; k < 4; k++) begin
      push(K_ACK, NCH'(1) << ord[k], '0);
      push(K_WRD, NCH'(1) << ord[k], '0);
    end
    ch_wr_req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_wrv($sformatf("t2_wait%0d", k));
      chk($sformatf("t2_addr%0d", k),  DW'(address), DW'(32'h100 * 32'(ord[k])));
      chk($sformatf("t2_wdata%0d", k), write_data,   wd[ord[k]]);
      step(); step();
      write_done = 1'b1;
      if (k == 3) ch_wr_req = '0;
      step();
      write_done = 1'b0;
      chk($sformatf("t2_wrv_low%0d", k), DW'(wrv), DW'(0));
    end
    step();

    // Test 3: channel 1 read+write together; read goes first
    ch_addr[1] = 32'h80; ch_rd_req[1] = 1'b1; ch_wr_req[1] = 1'b1;
    push(K_ACK, 4'b0010, '0);
    push(K_RDV, 4'b0010, d_r);
    push(K_ACK, 4'b0010, '0);
    push(K_WRD, 4'b0010, '0);
    step();
    chk("t3_rd_first", DW'(rrv), DW'(1));
    chk("t3_no_wr",    DW'(wrv), DW'(0));
    ch_rd_req[1] = 1'b0;
    step();
    read_data = d_r; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    step();
    chk("t3_wr_later", DW'(wrv),   DW'(1));
    chk("t3_wdata",    write_data, wd[1]);
    ch_wr_req[1] = 1'b0;
    step();
    write_done = 1'b1;
    step();
    write_done = 1'b0;
    chk("t3_wrv_low", DW'(wrv), DW'(0));
    step();

    // Test 4: no grants while buffer_addr_valid is low
    bav = 1'b0; ch_addr[0] = 32'h200; ch_rd_req[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t4_noack%0d", i), DW'(ch_ack), DW'(0));
      chk($sformatf("t4_norrv%0d", i), DW'(rrv | wrv), DW'(0));
    end
    push(K_ACK, 4'b0001, '0);
    bav = 1'b1;
    step();
    chk("t4_rrv",  DW'(rrv),     DW'(1));
    chk("t4_addr", DW'(address), DW'(32'h200));
    ch_rd_req[0] = 1'b0;
    bav = 1'b0;           // in-flight request must still complete
    write_done = 1'b1;    // wrong completion type: ignored
    step();
    write_done = 1'b0;
    chk("t4_mismatch_hold", DW'(rrv),        DW'(1));
    chk("t4_mismatch_wrd",  DW'(ch_wr_done), DW'(0));
    push(K_RDV, 4'b0001, d_c);
    read_data = d_c; data_valid = 1'b1;
    step();
    data_valid = 1'b0; bav = 1'b1;
    chk("t4_rrv_low", DW'(rrv), DW'(0));
    step();

    // Test 5: reset in RD_BUSY, late completion ignored, rr_ptr back to 0
    ch_addr[2] = 32'h300; ch_rd_req[2] = 1'b1;
    push(K_ACK, 4'b0100, '0);
    step();
    chk("t5_rrv", DW'(rrv), DW'(1));
    ch_rd_req[2] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_abort", DW'(rrv), DW'(0));
    read_data = d_d; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    chk("t5_late_dv", DW'(ch_rd_vld), DW'(0));
    chk("t5_idle",    DW'(rrv | wrv), DW'(0));
    push(K_ACK, 4'b0001, '0);
    push(K_WRD, 4'b0001, '0);
    ch_wr_req = 4'b1001;
    step();
    chk("t5_ptr0_wrv",  DW'(wrv),     DW'(1));
    chk("t5_ptr0_addr", DW'(address), DW'(32'h200));
    ch_wr_req = '0;
    step();
    write_done = 1'b1;
    step();
    write_done = 1'b0;
    step();

    // Test 6: watchdog
`ifdef MEM_ARB_TIMEOUT_EN
    push(K_ACK, 4'b0010, '0);
    push(K_ERR, 4'b0010, '0);
    ch_wr_req[1] = 1'b1;
    step();
    ch_wr_req[1] = 1'b0;
    nb = 0;
    while (wrv && nb < 20) begin
      nb++;
      step();
    end
    chk("t6_busy_cycles", DW'(nb),         DW'(8));
    chk("t6_err",         DW'(ch_err),     DW'(4'b0010));
    chk("t6_sticky",      DW'(err_sticky), DW'(1));
    step(); step();
    chk("t6_sticky_hold", DW'(err_sticky), DW'(1));
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_sticky_clr",  DW'(err_sticky), DW'(0));
`else
    push(K_ACK, 4'b0010, '0);
    push(K_WRD, 4'b0010, '0);
    ch_wr_req[1] = 1'b1;
    step();
    ch_wr_req[1] = 1'b0;
    repeat (20) step();
    chk("t6_waits",     DW'(wrv),        DW'(1));
    chk("t6_no_err",    DW'(ch_err),     DW'(0));
    chk("t6_no_sticky", DW'(err_sticky), DW'(0));
    write_done = 1'b1;
    step();
    write_done = 1'b0;
    chk("t6_wrv_low", DW'(wrv), DW'(0));
`endif

    repeat (3) step();
    chk("sb_drained", DW'(exp_q.size()), DW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
